sd_read_scheduler: RTL and testbench
====================================

Name: sd_read_scheduler

Overview:
Session controller placed between sd_file_reader and downstream byte consumers such as the UART transmitter or the character counter.
- Sequences one read session per start request: drives the reader's active-low reset, waits for file_found with a timeout, and captures the outen/outbyte stream.
- Buffers the captured bytes in a FIFO, because the reader has no backpressure, and presents them on a valid/ready stream with tlast on the final byte.
- Reports done, error code and byte count.

Parameters:
RESET_CYCLES, 16, cycles rd_rstn is held low at session start (at least 2)
FIFO_EA, 10, log2 of FIFO depth (depth 1024 bytes)
TIMEOUT_CYCLES, 200_000_000, cycles allowed from reader release to file_found (2 s at 100 MHz)
COUNT_W, 32, width of byte_count

Ports:
clk  in  1  system clock (100 MHz board clock)
rst  in  1  reset, synchronous, active-high
start  in  1  one-cycle request to begin a session; ignored while busy
abort  in  1  one-cycle request to cancel the current session
rd_rstn  out  1  active-low reset to sd_file_reader
rd_file_found  in  1  file_found from the reader
rd_outen  in  1  byte strobe from the reader
rd_outbyte  in  8  byte from the reader
rd_end  in  1  endFile from the reader (level)
o_tvalid  out  1  output byte valid
o_tready  in  1  consumer ready
o_tdata  out  8  output byte
o_tlast  out  1  marks the final byte of the file
busy  out  1  session in progress
done  out  1  one-cycle pulse on successful completion
err  out  2  0=none, 1=not found/timeout, 2=FIFO overflow, 3=aborted; sticky until next start
byte_count  out  COUNT_W  bytes accepted into the FIFO this session

Behaviour:
- Reset values: rd_rstn=0, o_tvalid=0, o_tdata=0, o_tlast=0, busy=0, done=0, err=0, byte_count=0, FIFO empty, state IDLE. rst mid-session returns all of these at the next edge.
- States: IDLE, RST_RDR, WAIT_FOUND, STREAM, DRAIN, DONE, ERROR. busy=1 in RST_RDR, WAIT_FOUND, STREAM and DRAIN.
- IDLE/ERROR/DONE + start: go to RST_RDR. Clear err, byte_count and FIFO. Drive rd_rstn=0.
- RST_RDR: hold rd_rstn=0 for exactly RESET_CYCLES cycles, then rd_rstn=1 and go to WAIT_FOUND with the timer cleared.
- WAIT_FOUND transitions:
  - rd_file_found=1: go to STREAM. Bytes strobed in the same cycle are captured.
  - Timer reaches TIMEOUT_CYCLES-1, or rd_end=1 with found=0: go to ERROR with err=1.
- STREAM, each rd_outen=1:
  - Push rd_outbyte and increment byte_count (wraps at 2^COUNT_W).
  - If the FIFO is full with no pop in the same cycle, the byte is dropped, byte_count is not incremented, and the state goes to ERROR with err=2.
  - Push and pop in the same cycle are legal at full.
- STREAM + rd_end=1: go to DRAIN. A byte strobed in the same cycle is pushed first. No pushes are accepted in DRAIN.
- DRAIN: o_tlast = o_tvalid & (FIFO occupancy == 1). When the FIFO is empty, go to DONE. A zero-length file reaches DONE with no tlast ever asserted.
- DONE: done=1 for exactly one cycle, then IDLE. rd_rstn stays 1 so file_found remains visible.
- ERROR: rd_rstn=0, FIFO flushed, o_tvalid=0. err holds. Only start or rst leaves this state.
- abort in any busy state: next cycle go to IDLE with rd_rstn=0, FIFO flushed, o_tvalid=0, err=3. abort has priority over every other event; abort in IDLE, DONE or ERROR is ignored.
- Output handshake:
  - The FIFO is first-word fall-through. A byte pushed in cycle N appears on o_tdata/o_tvalid in N+1 if the FIFO was empty.
  - A pop occurs when o_tvalid & o_tready.
  - While o_tvalid & !o_tready, o_tdata and o_tlast stay stable.
- start while busy is ignored. start and abort in the same cycle in IDLE: start wins, since abort is ignored in IDLE.

Decomposition:
- Package sd_sched_pkg holds the state encoding (localparams for the 7 states) and the err code constants.
- One sub-module, sd_sched_fifo: synchronous FWFT FIFO, 8-bit data, depth 2^FIFO_EA, with flush, full, empty and occupancy outputs.
- The FSM, timer and counters live in the top.

Test Plan:
- Reader model sends 5 bytes 0x41..0x45 then rd_end, o_tready=1 -> o_tdata sequence 41..45, o_tlast only on 0x45, done pulses once, byte_count=5, err=0.
- Same stream with o_tready held 0 for 50 cycles then released -> no data lost, o_tdata stable while stalled, tlast still on 5th byte.
- rd_file_found never asserts, TIMEOUT_CYCLES=100 -> rd_rstn falls at release+100 cycles, err=1, busy=0, no o_tvalid.
- FIFO_EA=2, 6 bytes, o_tready=0 -> 4 bytes accepted, byte_count=4, err=2, FIFO flushed, rd_rstn=0.
- abort mid-STREAM after 3 bytes -> next cycle IDLE, o_tvalid=0, err=3, then start -> rd_rstn low exactly RESET_CYCLES cycles, err cleared.
- rd_end coincident with last rd_outen (byte 0x7E) -> 0x7E delivered with o_tlast=1; a zero-length file gives done with no tvalid.

Source files
------------

// File: rtl/sd_sched_pkg.sv
// Shared state encoding and error codes for the SD read session scheduler.
package sd_sched_pkg;
  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_RST_RDR    = 3'd1;
  localparam logic [2:0] ST_WAIT_FOUND = 3'd2;
  localparam logic [2:0] ST_STREAM     = 3'd3;
  localparam logic [2:0] ST_DRAIN      = 3'd4;
  localparam logic [2:0] ST_DONE       = 3'd5;
  localparam logic [2:0] ST_ERROR      = 3'd6;

  typedef enum logic [2:0] {
    IDLE       = ST_IDLE,
    RST_RDR    = ST_RST_RDR,
    WAIT_FOUND = ST_WAIT_FOUND,
    STREAM     = ST_STREAM,
    DRAIN      = ST_DRAIN,
    DONE       = ST_DONE,
    ERROR      = ST_ERROR
  } state_e;

  localparam logic [1:0] ERR_NONE      = 2'd0;
  localparam logic [1:0] ERR_NOT_FOUND = 2'd1;
  localparam logic [1:0] ERR_OVERFLOW  = 2'd2;
  localparam logic [1:0] ERR_ABORTED   = 2'd3;

  function automatic logic is_busy(input state_e s);
    return (s == RST_RDR) || (s == WAIT_FOUND) || (s == STREAM) || (s == DRAIN);
  endfunction
endpackage

// File: rtl/sd_read_scheduler_if.sv
// Byte stream toward the downstream consumer (valid/ready with last marker).
interface sd_read_scheduler_if;
  logic       tvalid;
  logic       tready;
  logic [7:0] tdata;
  logic       tlast;

  modport master (output tvalid, output tdata, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/sd_sched_fifo.sv
// First-word-fall-through byte FIFO with synchronous flush; flush beats push/pop.
module sd_sched_fifo #(
  parameter int EA = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        push,
  input  logic [7:0]  din,
  input  logic        pop,
  output logic [7:0]  dout,
  output logic        full,
  output logic        empty,
  output logic [EA:0] count
);
  localparam int DEPTH = 1 << EA;

  logic [7:0]  mem_q [DEPTH];
  logic [EA:0] wr_q, wr_d, rd_q, rd_d;
  logic        push_ok, pop_ok;

  // Pointers carry one extra bit so a full FIFO reads as count == DEPTH.
  assign count   = wr_q - rd_q;
  assign empty   = (count == '0);
  assign full    = count[EA];
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign dout    = mem_q[rd_q[EA-1:0]];

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (flush) begin
      wr_d = '0;
      rd_d = '0;
    end else begin
      if (push_ok) wr_d = wr_q + 1'b1;
      if (pop_ok)  rd_d = rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem_q[wr_q[EA-1:0]] <= din;
  end
endmodule

// File: rtl/sd_read_scheduler.sv
// Runs one sd_file_reader session per start: resets the reader, waits for the
// file, buffers its unthrottled byte stream and replays it on a valid/ready port.
module sd_read_scheduler
  import sd_sched_pkg::*;
#(
  parameter int RESET_CYCLES   = 16,
  parameter int FIFO_EA        = 10,
  parameter int TIMEOUT_CYCLES = 200_000_000,
  parameter int COUNT_W        = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  output logic               rd_rstn,
  input  logic               rd_file_found,
  input  logic               rd_outen,
  input  logic [7:0]         rd_outbyte,
  input  logic               rd_end,
  sd_read_scheduler_if.master o,
  output logic               busy,
  output logic               done,
  output logic [1:0]         err,
  output logic [COUNT_W-1:0] byte_count
);
  localparam int RC_W = $clog2(RESET_CYCLES);
  localparam int TM_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [RC_W-1:0] RC_LAST = RC_W'(RESET_CYCLES - 1);
  localparam logic [TM_W-1:0] TM_LAST = TM_W'(TIMEOUT_CYCLES - 1);

  state_e             state_q, state_d;
  logic [RC_W-1:0]    rc_q, rc_d;
  logic [TM_W-1:0]    tm_q, tm_d;
  logic [COUNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]         err_q, err_d;
  logic               rd_rstn_q, rd_rstn_d;
  logic               capture, flush, push, pop, streaming;
  logic [7:0]         f_dout;
  logic               f_full, f_empty;
  logic [FIFO_EA:0]   f_count;

  sd_sched_fifo #(.EA(FIFO_EA)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (push),
    .din   (rd_outbyte),
    .pop   (pop),
    .dout  (f_dout),
    .full  (f_full),
    .empty (f_empty),
    .count (f_count)
  );

  // Outputs are gated by state so stale FIFO contents never leak out of ERROR/IDLE.
  assign streaming  = (state_q == STREAM) || (state_q == DRAIN);
  assign o.tvalid   = streaming & ~f_empty;
  assign o.tdata    = o.tvalid ? f_dout : 8'h00;
  assign o.tlast    = o.tvalid & (state_q == DRAIN) & (f_count == {{FIFO_EA{1'b0}}, 1'b1});
  assign pop        = o.tvalid & o.tready;
  assign busy       = is_busy(state_q);
  assign done       = (state_q == DONE);
  assign err        = err_q;
  assign byte_count = cnt_q;
  assign rd_rstn    = rd_rstn_q;

  always_comb begin
    state_d   = state_q;
    rc_d      = rc_q;
    tm_d      = tm_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    rd_rstn_d = rd_rstn_q;
    flush     = 1'b0;
    push      = 1'b0;
    capture   = 1'b0;
    if (busy && abort) begin
      state_d   = IDLE;
      rd_rstn_d = 1'b0;
      flush     = 1'b1;
      err_d     = ERR_ABORTED;
    end else begin
      case (state_q)
        IDLE, DONE, ERROR: begin
          if (start) begin
            state_d   = RST_RDR;
            rc_d      = '0;
            cnt_d     = '0;
            err_d     = ERR_NONE;
            rd_rstn_d = 1'b0;
            flush     = 1'b1;
          end else if (state_q == DONE) begin
            state_d = IDLE;
          end
        end
        RST_RDR: begin
          if (rc_q == RC_LAST) begin
            state_d   = WAIT_FOUND;
            rd_rstn_d = 1'b1;
            tm_d      = '0;
          end else begin
            rc_d = rc_q + 1'b1;
          end
        end
        WAIT_FOUND: begin
          if (rd_file_found) begin
            state_d = STREAM;
            capture = 1'b1;
          end else if (tm_q == TM_LAST || rd_end) begin
            state_d   = ERROR;
            err_d     = ERR_NOT_FOUND;
            rd_rstn_d = 1'b0;
            flush     = 1'b1;
          end else begin
            tm_d = tm_q + 1'b1;
          end
        end
        STREAM: begin
          capture = 1'b1;
          if (rd_end) state_d = DRAIN;
        end
        DRAIN: if (f_empty) state_d = DONE;
        default: state_d = IDLE;
      endcase
      // The reader cannot be stalled, so a byte arriving at a full FIFO is fatal.
      if (capture && rd_outen) begin
        if (f_full && !pop) begin
          state_d   = ERROR;
          err_d     = ERR_OVERFLOW;
          rd_rstn_d = 1'b0;
          flush     = 1'b1;
        end else begin
          push  = 1'b1;
          cnt_d = cnt_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      rc_q      <= '0;
      tm_q      <= '0;
      cnt_q     <= '0;
      err_q     <= ERR_NONE;
      rd_rstn_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rc_q      <= rc_d;
      tm_q      <= tm_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      rd_rstn_q <= rd_rstn_d;
    end
  end
endmodule

// File: tb/tb_sd_read_scheduler.sv
// Scoreboard bench: reader stimulus pushes expected beats, a negedge monitor pops them.
module tb_sd_read_scheduler;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // DUT A: deep FIFO, short timeout
  logic        start_a = 1'b0, abort_a = 1'b0, found_a = 1'b0, outen_a = 1'b0, end_a = 1'b0;
  logic [7:0]  byte_a = 8'h00;
  logic        rd_rstn_a, busy_a, done_a;
  logic [1:0]  err_a;
  logic [31:0] cnt_a;
  // DUT B: 4-entry FIFO for overflow
  logic        start_b = 1'b0, abort_b = 1'b0, found_b = 1'b0, outen_b = 1'b0, end_b = 1'b0;
  logic [7:0]  byte_b = 8'h00;
  logic        rd_rstn_b, busy_b, done_b;
  logic [1:0]  err_b;
  logic [31:0] cnt_b;

  sd_read_scheduler_if ia();
  sd_read_scheduler_if ib();

  sd_read_scheduler #(.RESET_CYCLES(16), .FIFO_EA(4), .TIMEOUT_CYCLES(100), .COUNT_W(32)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .abort(abort_a), .rd_rstn(rd_rstn_a),
    .rd_file_found(found_a), .rd_outen(outen_a), .rd_outbyte(byte_a), .rd_end(end_a),
    .o(ia), .busy(busy_a), .done(done_a), .err(err_a), .byte_count(cnt_a));

  sd_read_scheduler #(.RESET_CYCLES(16), .FIFO_EA(2), .TIMEOUT_CYCLES(100), .COUNT_W(32)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .abort(abort_b), .rd_rstn(rd_rstn_b),
    .rd_file_found(found_b), .rd_outen(outen_b), .rd_outbyte(byte_b), .rd_end(end_b),
    .o(ib), .busy(busy_b), .done(done_b), .err(err_b), .byte_count(cnt_b));

  typedef struct packed { logic [7:0] d; logic l; } beat_t;
  beat_t exp_q[$];
  int total = 0, passed = 0, beats = 0, dones = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, required %0h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: consumes beats, checks ordering, tlast and stall stability.
  initial begin
    logic       stall_p;
    logic [7:0] stall_d;
    beat_t      e;
    stall_p = 1'b0;
    stall_d = 8'h00;
    forever begin
      @(negedge clk);
      if (ia.tvalid && stall_p) check("stall_stable", 32'(ia.tdata), 32'(stall_d));
      stall_p = ia.tvalid && !ia.tready;
      stall_d = ia.tdata;
      if (ia.tvalid && ia.tready) begin
        beats++;
        if (exp_q.size() == 0) begin
          total++;
          $display("FAIL beat_unexpected: got data %02h last %0b, required no beat", ia.tdata, ia.tlast);
        end else begin
          e = exp_q.pop_front();
          check("beat_data_last", 32'({ia.tdata, ia.tlast}), 32'(e));
        end
      end
      if (done_a) dones++;
    end
  end

  task automatic start_pulse_a();
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
  endtask

  task automatic wait_release_a();
    int n = 0;
    while (!rd_rstn_a && n < 100) begin tick(); n++; end
    check("release_a", 32'(rd_rstn_a), 1);
  endtask

  task automatic send_a(input logic [7:0] base, input int n, input bit expect_out, input bit end_coinc);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      outen_a = 1'b1;
      byte_a  = base + 8'(i);
      if (end_coinc && i == n - 1) end_a = 1'b1;
      if (expect_out) begin
        b.d = base + 8'(i);
        b.l = (i == n - 1);
        exp_q.push_back(b);
      end
      tick();
      outen_a = 1'b0;
      tick();
    end
  endtask

  task automatic wait_done_a(input string nm);
    int n = 0;
    int d0 = dones;
    while (dones == d0 && n < 300) begin tick(); n++; end
    repeat (3) tick();
    check(nm, dones - d0, 1);
  endtask

  initial begin
    int n, b0;
    ia.tready = 1'b1;
    ib.tready = 1'b0;
    repeat (3) tick();
    check("rst_rd_rstn", 32'(rd_rstn_a), 0);
    check("rst_tvalid", 32'(ia.tvalid), 0);
    check("rst_tdata", 32'(ia.tdata), 0);
    check("rst_tlast", 32'(ia.tlast), 0);
    check("rst_busy", 32'(busy_a), 0);
    check("rst_done", 32'(done_a), 0);
    check("rst_err", 32'(err_a), 0);
    check("rst_count", cnt_a, 0);
    check("rst_b_rd_rstn", 32'(rd_rstn_b), 0);
    rst = 1'b0;
    tick();

    // Five bytes, consumer always ready, end coincident with last byte
    b0 = beats;
    start_pulse_a();
    check("busy_after_start", 32'(busy_a), 1);
    wait_release_a();
    found_a = 1'b1;
    tick();
    send_a(8'h41, 5, 1'b1, 1'b1);
    wait_done_a("t1_done_once");
    check("t1_beats", beats - b0, 5);
    check("t1_count", cnt_a, 5);
    check("t1_err", 32'(err_a), 0);
    check("t1_queue_empty", exp_q.size(), 0);
    check("t1_rd_rstn_held", 32'(rd_rstn_a), 1);
    found_a = 1'b0;
    end_a = 1'b0;

    // Same stream while consumer stalls, end arrives after the bytes
    ia.tready = 1'b0;
    b0 = beats;
    start_pulse_a();
    wait_release_a();
    found_a = 1'b1;
    tick();
    send_a(8'h41, 5, 1'b1, 1'b0);
    end_a = 1'b1;
    repeat (50) tick();
    check("t2_no_beats_stalled", beats - b0, 0);
    check("t2_tvalid_stalled", 32'(ia.tvalid), 1);
    check("t2_head_stalled", 32'(ia.tdata), 32'h41);
    ia.tready = 1'b1;
    wait_done_a("t2_done_once");
    check("t2_beats", beats - b0, 5);
    check("t2_count", cnt_a, 5);
    check("t2_err", 32'(err_a), 0);
    check("t2_queue_empty", exp_q.size(), 0);
    found_a = 1'b0;
    end_a = 1'b0;

    // file_found never arrives
    b0 = beats;
    start_pulse_a();
    wait_release_a();
    n = 0;
    while (rd_rstn_a && n < 1000) begin n++; tick(); end
    check("t3_timeout_cycles", n, 100);
    check("t3_err", 32'(err_a), 1);
    check("t3_busy", 32'(busy_a), 0);
    check("t3_no_beats", beats - b0, 0);

    // Abort with three bytes buffered, then restart
    ia.tready = 1'b0;
    start_pulse_a();
    wait_release_a();
    found_a = 1'b1;
    tick();
    send_a(8'h30, 3, 1'b0, 1'b0);
    check("t5_tvalid_before", 32'(ia.tvalid), 1);
    check("t5_count_before", cnt_a, 3);
    abort_a = 1'b1;
    tick();
    abort_a = 1'b0;
    check("t5_busy", 32'(busy_a), 0);
    check("t5_tvalid", 32'(ia.tvalid), 0);
    check("t5_err", 32'(err_a), 3);
    check("t5_rd_rstn", 32'(rd_rstn_a), 0);
    found_a = 1'b0;
    ia.tready = 1'b1;
    start_pulse_a();
    check("t5_err_cleared", 32'(err_a), 0);
    n = 0;
    while (!rd_rstn_a && n < 1000) begin n++; tick(); end
    check("t5_reset_cycles", n, 16);

    // End coincident with last byte 0x7E in the restarted session
    found_a = 1'b1;
    tick();
    send_a(8'h7C, 3, 1'b1, 1'b1);
    wait_done_a("t6_done_once");
    check("t6_count", cnt_a, 3);
    check("t6_queue_empty", exp_q.size(), 0);
    found_a = 1'b0;
    end_a = 1'b0;

    // Zero-length file
    b0 = beats;
    start_pulse_a();
    wait_release_a();
    found_a = 1'b1;
    tick();
    end_a = 1'b1;
    wait_done_a("t6_zero_done_once");
    check("t6_zero_beats", beats - b0, 0);
    check("t6_zero_count", cnt_a, 0);
    check("t6_zero_err", 32'(err_a), 0);
    found_a = 1'b0;
    end_a = 1'b0;

    // Overflow on the 4-entry instance, consumer never ready
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    n = 0;
    while (!rd_rstn_b && n < 100) begin tick(); n++; end
    check("t4_release", 32'(rd_rstn_b), 1);
    found_b = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) begin
      outen_b = 1'b1;
      byte_b  = 8'h10 + 8'(i);
      tick();
      outen_b = 1'b0;
      if (i == 3) begin
        check("t4_full_head", 32'(ib.tdata), 32'h10);
        check("t4_full_count", cnt_b, 4);
      end
      tick();
    end
    check("t4_count", cnt_b, 4);
    check("t4_err", 32'(err_b), 2);
    check("t4_rd_rstn", 32'(rd_rstn_b), 0);
    check("t4_tvalid", 32'(ib.tvalid), 0);
    check("t4_busy", 32'(busy_b), 0);
    check("t4_done", 32'(done_b), 0);
    found_b = 1'b0;

    repeat (3) tick();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d passed so far", passed, total);
    $fatal(1, "watchdog expired");
  end
endmodule
